// File: rtl/rv_instr_decoder_pkg.sv
// Shared types and the RV32I decode function for the instruction decoder.
// Covers addi, add, beq and jal; everything else decodes as illegal.
package rv_dec_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DIR_WIDTH  = 5;
  localparam int CNT_WIDTH  = 16;

  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_ADD  = 7'b0110011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    ADDI = 2'd0,
    ADD  = 2'd1,
    BEQ  = 2'd2,
    JAL  = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } occ_state_e;

  typedef struct packed {
    op_class_e             op_class;
    logic [DIR_WIDTH-1:0]  rd;
    logic [DIR_WIDTH-1:0]  rs1;
    logic [DIR_WIDTH-1:0]  rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic                  reg_write;
    logic                  alu_src_imm;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
  } dec_entry_t;

  // Register fields always carry the raw bits; only a recognised op clears
  // the illegal flag and fills in immediate and control bits.
  function automatic dec_entry_t decode(input logic [DATA_WIDTH-1:0] word);
    dec_entry_t e;
    logic [2:0] funct3;
    logic [6:0] funct7;
    funct3    = word[14:12];
    funct7    = word[31:25];
    e         = '0;
    e.op_class = ADDI;
    e.rd      = word[11:7];
    e.rs1     = word[19:15];
    e.rs2     = word[24:20];
    e.illegal = 1'b1;
    case (word[6:0])
      OPC_ADDI: if (funct3 == 3'b000) begin
        e.op_class    = ADDI;
        e.imm         = {{20{word[31]}}, word[31:20]};
        e.reg_write   = (e.rd != '0);
        e.alu_src_imm = 1'b1;
        e.illegal     = 1'b0;
      end
      OPC_ADD: if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
        e.op_class  = ADD;
        e.reg_write = (e.rd != '0);
        e.illegal   = 1'b0;
      end
      OPC_BEQ: if (funct3 == 3'b000) begin
        e.op_class = BEQ;
        e.imm      = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
        e.branch   = 1'b1;
        e.illegal  = 1'b0;
      end
      OPC_JAL: begin
        e.op_class  = JAL;
        e.imm       = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
        e.reg_write = (e.rd != '0);
        e.jump      = 1'b1;
        e.illegal   = 1'b0;
      end
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rv_instr_decoder_if.sv
// Instruction-in / decoded-fields-out bus of the decoder.
// slave is the decoder side, master is the upstream/datapath side.
interface rv_instr_decoder_if;
  import rv_dec_pkg::*;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instruction;

  logic                  dec_valid;
  logic                  dec_ready;
  op_class_e             op_class;
  logic [DIR_WIDTH-1:0]  rd;
  logic [DIR_WIDTH-1:0]  rs1;
  logic [DIR_WIDTH-1:0]  rs2;
  logic [DATA_WIDTH-1:0] imm;
  logic                  reg_write;
  logic                  alu_src_imm;
  logic                  branch;
  logic                  jump;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  illegal_cnt;

  modport slave (
    input  instr_valid, instruction, dec_ready,
    output instr_ready, dec_valid, op_class, rd, rs1, rs2, imm,
           reg_write, alu_src_imm, branch, jump, illegal, illegal_cnt
  );

  modport master (
    output instr_valid, instruction, dec_ready,
    input  instr_ready, dec_valid, op_class, rd, rs1, rs2, imm,
           reg_write, alu_src_imm, branch, jump, illegal, illegal_cnt
  );

endinterface

// File: rtl/rv_instr_decoder.sv
// RV32I decoder with registered outputs and a 2-entry skid buffer, so the
// upstream ready is a flop and no word is dropped when the datapath stalls.
module rv_instr_decoder
  import rv_dec_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  rv_instr_decoder_if.slave bus
);

  occ_state_e           state_q, state_d;
  dec_entry_t           out_q, out_d;
  dec_entry_t           skid_q, skid_d;
  dec_entry_t           new_entry;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;
  logic                 retire;

  assign new_entry = decode(bus.instruction);
  assign accept    = bus.instr_valid && ready_q;
  assign retire    = (state_q != EMPTY) && bus.dec_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        out_d   = new_entry;
        state_d = FULL1;
      end
      FULL1: case ({accept, retire})
        2'b10: begin
          skid_d  = new_entry;
          state_d = FULL2;
        end
        2'b11: out_d = new_entry;
        2'b01: state_d = EMPTY;
        default: ;
      endcase
      FULL2: if (retire) begin
        out_d   = skid_q;
        state_d = FULL1;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && new_entry.illegal && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ready_q <= (state_d != FULL2);
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the skid register is always written before it is read (only in
  // FULL2), so it carries no reset; the visible output register does.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.instr_ready = ready_q;
  assign bus.dec_valid   = (state_q != EMPTY);
  assign bus.op_class    = out_q.op_class;
  assign bus.rd          = out_q.rd;
  assign bus.rs1         = out_q.rs1;
  assign bus.rs2         = out_q.rs2;
  assign bus.imm         = out_q.imm;
  assign bus.reg_write   = out_q.reg_write;
  assign bus.alu_src_imm = out_q.alu_src_imm;
  assign bus.branch      = out_q.branch;
  assign bus.jump        = out_q.jump;
  assign bus.illegal     = out_q.illegal;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv_instr_decoder.sv
// Self-checking bench: a queue-based occupancy model with an arithmetic
// decoder, checked every cycle, plus directed literal expectations.
module tb_rv_instr_decoder;
  import rv_dec_pkg::*;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  rv_instr_decoder_if bus ();

  rv_instr_decoder dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [53:0] pk(input logic [1:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm, input logic rw, input logic asi,
                                     input logic br, input logic jp, input logic ill);
    return {op, rd, rs1, rs2, imm, rw, asi, br, jp, ill};
  endfunction

  // Reference decoder: immediates rebuilt as weighted sums of bit fields.
  function automatic logic [53:0] model_decode(input logic [31:0] w);
    int   imm;
    logic [1:0] op;
    logic rw, asi, br, jp, ill;
    imm = 0; op = 2'd0; rw = 0; asi = 0; br = 0; jp = 0; ill = 0;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      op = 2'd0; asi = 1; rw = (w[11:7] != 0);
      imm = int'(w[30:20]) - (w[31] ? 2048 : 0);
    end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) begin
      op = 2'd1; rw = (w[11:7] != 0);
    end else if (w[6:0] == 7'h63 && w[14:12] == 3'd0) begin
      op = 2'd2; br = 1;
      imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - (w[31] ? 4096 : 0);
    end else if (w[6:0] == 7'h6F) begin
      op = 2'd3; jp = 1; rw = (w[11:7] != 0);
      imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
            - (w[31] ? (1 << 20) : 0);
    end else begin
      ill = 1;
    end
    return pk(op, w[11:7], w[19:15], w[24:20], imm, rw, asi, br, jp, ill);
  endfunction

  logic [53:0] dut_vec;
  assign dut_vec = {bus.op_class, bus.rd, bus.rs1, bus.rs2, bus.imm,
                    bus.reg_write, bus.alu_src_imm, bus.branch, bus.jump, bus.illegal};

  // Occupancy model: a FIFO of at most two decoded entries.
  logic [53:0] exp_q[$];
  int          exp_cnt = 0;
  bit          clocked = 0;
  bit          m_acc, m_ret;
  logic [53:0] m_new;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      exp_q.delete();
      exp_cnt = 0;
      clocked = 0;
    end else begin
      m_acc = bus.instr_valid && clocked && (exp_q.size() < 2);
      m_ret = (exp_q.size() != 0) && bus.dec_ready;
      m_new = model_decode(bus.instruction);
      if (m_ret) void'(exp_q.pop_front());
      if (m_acc) begin
        exp_q.push_back(m_new);
        if (m_new[0] && exp_cnt < 65535) exp_cnt++;
      end
      clocked = 1;
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      check("instr_ready", bus.instr_ready, clocked && (exp_q.size() < 2));
      check("dec_valid", bus.dec_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("fields", dut_vec, exp_q[0]);
      check("illegal_cnt", bus.illegal_cnt, exp_cnt);
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic r);
    bus.instr_valid = v;
    bus.instruction = w;
    bus.dec_ready   = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " dec_valid"}, bus.dec_valid, 0);
    check({tag, " instr_ready"}, bus.instr_ready, 0);
    check({tag, " fields"}, dut_vec, 0);
    check({tag, " illegal_cnt"}, bus.illegal_cnt, 0);
  endtask

  localparam logic [31:0] W_ADDI = 32'hFFF18293;
  localparam logic [31:0] W_ADD  = 32'h003100B3;
  localparam logic [31:0] W_BEQ  = 32'hFE208CE3;
  localparam logic [31:0] W_JAL  = 32'h010000EF;
  localparam logic [31:0] W_SUB  = 32'h403100B3;

  logic [31:0] vec_w[7];
  logic [53:0] vec_e[7];
  logic [31:0] w;

  initial begin
    vec_w[0] = W_ADDI;       vec_e[0] = pk(0, 5, 3, 31, 32'hFFFFFFFF, 1, 1, 0, 0, 0);
    vec_w[1] = W_ADD;        vec_e[1] = pk(1, 1, 2, 3, 32'h0, 1, 0, 0, 0, 0);
    vec_w[2] = W_BEQ;        vec_e[2] = pk(2, 25, 1, 2, 32'hFFFFFFF8, 0, 0, 1, 0, 0);
    vec_w[3] = W_JAL;        vec_e[3] = pk(3, 1, 0, 16, 32'h10, 1, 0, 0, 1, 0);
    vec_w[4] = 32'h00100013; vec_e[4] = pk(0, 0, 0, 1, 32'h1, 0, 1, 0, 0, 0);
    vec_w[5] = 32'hFFDFF06F; vec_e[5] = pk(3, 0, 31, 29, 32'hFFFFFFFC, 0, 0, 0, 1, 0);
    vec_w[6] = 32'hFE209CE3; vec_e[6] = pk(0, 25, 1, 2, 32'h0, 0, 0, 0, 0, 1);

    drive(0, 32'h0, 0);
    #1 arst_n = 1'b0;
    #2 check_reset_values("reset_hold");
    @(negedge clk);
    arst_n = 1'b1;
    #1 check_reset_values("reset_release");
    tick;
    check("ready_after_release", bus.instr_ready, 1);

    // Back-to-back stream with the datapath always ready.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("model_pin%0d", i), model_decode(vec_w[i]), vec_e[i]);
      drive(1, vec_w[i], 1);
      tick;
      check($sformatf("vec%0d valid", i), bus.dec_valid, 1);
      check($sformatf("vec%0d fields", i), dut_vec, vec_e[i]);
    end
    check("cnt_after_bne", bus.illegal_cnt, 1);
    drive(0, 32'h0, 1);
    tick;
    check("drained", bus.dec_valid, 0);

    // Stall: two words fill the buffer, a third is refused.
    drive(1, W_ADD, 0);
    tick;
    check("stall ready1", bus.instr_ready, 1);
    drive(1, W_ADDI, 0);
    tick;
    check("stall ready2", bus.instr_ready, 0);
    check("stall head", dut_vec, vec_e[1]);
    drive(1, W_JAL, 0);
    tick;
    check("stall third refused", bus.instr_ready, 0);
    check("stall hold", dut_vec, vec_e[1]);
    drive(0, 32'h0, 1);
    tick;
    check("retire first", dut_vec, vec_e[0]);
    check("retire ready back", bus.instr_ready, 1);
    tick;
    check("retire empty", bus.dec_valid, 0);

    // Illegal words and counter saturation.
    drive(1, W_SUB, 1);
    tick;
    check("sub fields", dut_vec, pk(0, 1, 2, 3, 32'h0, 0, 0, 0, 0, 1));
    check("sub cnt", bus.illegal_cnt, 2);
    for (int i = 0; i < 65533; i++) begin
      w = {i[24:0], 7'd0};
      drive(1, w, 1);
      tick;
    end
    check("cnt at max", bus.illegal_cnt, 16'hFFFF);
    drive(1, W_SUB, 1);
    tick;
    check("cnt saturated", bus.illegal_cnt, 16'hFFFF);
    drive(0, 32'h0, 1);
    tick;

    // Reset mid-cycle while FULL2.
    drive(1, W_ADD, 0);
    tick;
    drive(1, W_ADDI, 0);
    tick;
    check("full2 before reset", bus.instr_ready, 0);
    #3 arst_n = 1'b0;
    #1 check_reset_values("midreset");
    drive(0, 32'h0, 0);
    tick;
    tick;
    @(negedge clk);
    arst_n = 1'b1;
    #1 check_reset_values("midreset_release");
    tick;
    check("midreset ready", bus.instr_ready, 1);
    drive(1, W_BEQ, 0);
    tick;
    check("post reset fields", dut_vec, vec_e[2]);
    drive(0, 32'h0, 1);
    tick;
    check("no stale entry", bus.dec_valid, 0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
